// File: rtl/flex_buffer_pkg.sv
// Shared definitions for the flexible byte FIFO: transfer-size encodings
// and the size-to-byte-count helper used by the push/pop length logic.
package flex_buffer_pkg;

  // data_size carries (bytes - 1) of a word transfer
  localparam int unsigned SIZE_1B = 0;
  localparam int unsigned SIZE_2B = 1;
  localparam int unsigned SIZE_3B = 2;
  localparam int unsigned SIZE_4B = 3;
  localparam int unsigned SIZE_8B = 7;

  // number of bytes moved by a word transfer of the given size code
  function automatic int unsigned bytes_of(input int unsigned size);
    return size + 1;
  endfunction

endpackage

// File: rtl/flex_buffer_mem.sv
// Byte-wide storage for the FIFO. LANES write lanes and LANES read lanes,
// lane k addressing (base + k) mod DEPTH so word transfers wrap freely.
// Reads are combinational; the top registers the popped data. The array is
// never reset, so its contents are undefined until written.
module flex_buffer_mem #(
  parameter int DEPTH = 64,
  parameter int LANES = 4
) (
  input  logic                         clk,
  input  logic [LANES-1:0]             wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_base,
  input  logic [LANES-1:0][7:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0]     rd_base,
  output logic [LANES-1:0][7:0]        rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]                  mem [DEPTH];
  logic [LANES-1:0][AW-1:0]    wr_addr;
  logic [LANES-1:0][AW-1:0]    rd_addr;

  // per-lane addresses; truncation to AW bits gives the mod-DEPTH wrap
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign wr_addr[k] = wr_base + AW'(k);
    assign rd_addr[k] = rd_base + AW'(k);
    assign rd_data[k] = mem[rd_addr[k]];
  end

  // lane writes; active lanes always target distinct addresses
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_en[k]) mem[wr_addr[k]] <= wr_data[k];
    end
  end

endmodule

// File: rtl/flex_data_buffer.sv
// Byte FIFO shared between a USB byte stream and an AHB-Lite word port.
// Either side may push or pop; pushes are all-or-nothing, pops never read
// data written in the same cycle, and misuse is recorded in sticky flags.
module flex_data_buffer
  import flex_buffer_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WORD_BYTES  = 4,
  parameter int AFULL_LEVEL = 56
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          store_byte,
  input  logic [7:0]                    byte_in,
  input  logic                          get_byte,
  output logic [7:0]                    byte_out,
  input  logic                          store_word,
  input  logic                          get_word,
  input  logic [$clog2(WORD_BYTES)-1:0] data_size,
  input  logic [8*WORD_BYTES-1:0]       word_in,
  output logic [8*WORD_BYTES-1:0]       word_out,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          almost_full,
  output logic                          err_overflow,
  output logic                          err_underflow,
  output logic                          err_collision
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [PW-1:0]                 word_n, n_push, n_pop;
  logic                          push_req, pop_req;
  logic                          push_ok, pop_ok;
  logic                          push_go, pop_go;
  logic                          collide;
  logic [WORD_BYTES-1:0]         wr_en;
  logic [WORD_BYTES-1:0][7:0]    wr_data;
  logic [WORD_BYTES-1:0][7:0]    rd_data;

  // word transfers win over byte transfers on the same side
  assign word_n   = PW'(bytes_of(32'(data_size)));
  assign push_req = store_word | store_byte;
  assign pop_req  = get_word | get_byte;
  assign n_push   = store_word ? word_n : (store_byte ? PW'(1) : '0);
  assign n_pop    = get_word   ? word_n : (get_byte   ? PW'(1) : '0);
  assign collide  = (store_byte & store_word) | (get_byte & get_word);

  // both checks use the pre-cycle occupancy; wrap bit makes full != empty
  assign occupancy   = wr_ptr - rd_ptr;
  assign push_ok     = ({1'b0, occupancy} + {1'b0, n_push}) <= (PW+1)'(DEPTH);
  assign pop_ok      = occupancy >= n_pop;
  assign push_go     = push_req & push_ok & ~clear;
  assign pop_go      = pop_req & pop_ok & ~clear;
  assign almost_full = occupancy >= PW'(AFULL_LEVEL);

  // lane k carries byte k of the word, or the single byte on lane 0
  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_wlane
    assign wr_en[k]   = push_go & (PW'(k) < n_push);
    assign wr_data[k] = store_word ? word_in[8*k +: 8] : byte_in;
  end

  flex_buffer_mem #(
    .DEPTH (DEPTH),
    .LANES (WORD_BYTES)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_base (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_base (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  // pointer advance on accepted transfers; clear flushes both pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_go) wr_ptr <= wr_ptr + n_push;
      if (pop_go)  rd_ptr <= rd_ptr + n_pop;
    end
  end

  // registered pop data; a rejected pop or a clear leaves the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_out <= '0;
      word_out <= '0;
    end else if (pop_go) begin
      if (get_word) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          word_out[8*k +: 8] <= (PW'(k) < n_pop) ? rd_data[k] : 8'h00;
        end
      end else begin
        byte_out <= rd_data[0];
      end
    end
  end

  // sticky error flags, dropped only by clear or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_collision <= 1'b0;
    end else if (clear) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      if (push_req & ~push_ok) err_overflow  <= 1'b1;
      if (pop_req & ~pop_ok)   err_underflow <= 1'b1;
      if (collide)             err_collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flex_data_buffer.sv
// Bench for flex_data_buffer: directed scenarios followed by randomized
// traffic, all checked against a byte-queue reference model.
module tb_flex_data_buffer;

  localparam int DEPTH = 64;
  localparam int WB    = 4;
  localparam int AFULL = 56;

  logic        tb_clk = 1'b0;
  logic        rst, clear, store_byte, get_byte, store_word, get_word;
  logic [1:0]  data_size;
  logic [7:0]  byte_in, byte_out;
  logic [31:0] word_in, word_out;
  logic [6:0]  occupancy;
  logic        almost_full, err_overflow, err_underflow, err_collision;

  always #5 tb_clk = ~tb_clk;

  flex_data_buffer #(
    .DEPTH       (DEPTH),
    .WORD_BYTES  (WB),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .clear         (clear),
    .store_byte    (store_byte),
    .byte_in       (byte_in),
    .get_byte      (get_byte),
    .byte_out      (byte_out),
    .store_word    (store_word),
    .get_word      (get_word),
    .data_size     (data_size),
    .word_in       (word_in),
    .word_out      (word_out),
    .occupancy     (occupancy),
    .almost_full   (almost_full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_collision (err_collision)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: contents as a byte queue plus the visible registers
  logic [7:0]  mq[$];
  logic [7:0]  m_byte;
  logic [31:0] m_word;
  logic        m_ovf, m_udf, m_col;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_byte = '0;
    m_word = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_col  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/occ"},  64'(occupancy),     64'(mq.size()));
    chk({tag, "/af"},   64'(almost_full),   64'(mq.size() >= AFULL));
    chk({tag, "/byte"}, 64'(byte_out),      64'(m_byte));
    chk({tag, "/word"}, 64'(word_out),      64'(m_word));
    chk({tag, "/ovf"},  64'(err_overflow),  64'(m_ovf));
    chk({tag, "/udf"},  64'(err_underflow), 64'(m_udf));
    chk({tag, "/col"},  64'(err_collision), 64'(m_col));
  endtask

  task automatic idle();
    clear = 0; store_byte = 0; get_byte = 0; store_word = 0; get_word = 0;
    data_size = '0; byte_in = '0; word_in = '0;
  endtask

  // apply current inputs for one clock, advance the model, compare
  task automatic step(input string tag);
    int np, nq, occ;
    bit pok, qok;
    np = store_word ? int'(data_size) + 1 : (store_byte ? 1 : 0);
    nq = get_word   ? int'(data_size) + 1 : (get_byte   ? 1 : 0);
    if (clear) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_col = 0;
    end else begin
      occ = mq.size();
      pok = (np > 0) && (occ + np <= DEPTH);
      qok = (nq > 0) && (occ >= nq);
      if (np > 0 && !pok) m_ovf = 1;
      if (nq > 0 && !qok) m_udf = 1;
      if ((store_byte && store_word) || (get_byte && get_word)) m_col = 1;
      if (qok) begin
        if (get_word) begin
          m_word = '0;
          for (int k = 0; k < nq; k++) m_word[8*k +: 8] = mq.pop_front();
        end else begin
          m_byte = mq.pop_front();
        end
      end
      if (pok) begin
        if (store_word) for (int k = 0; k < np; k++) mq.push_back(word_in[8*k +: 8]);
        else mq.push_back(byte_in);
      end
    end
    @(posedge tb_clk);
    #1;
    check_all(tag);
    idle();
  endtask

  task automatic push_b(input logic [7:0] b);
    store_byte = 1; byte_in = b; step("push_b");
  endtask

  task automatic push_w(input logic [1:0] sz, input logic [31:0] w);
    store_word = 1; data_size = sz; word_in = w; step("push_w");
  endtask

  task automatic pop_b();
    get_byte = 1; step("pop_b");
  endtask

  task automatic pop_w(input logic [1:0] sz);
    get_word = 1; data_size = sz; step("pop_w");
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    @(posedge tb_clk);
    @(posedge tb_clk);
    #1;
    check_all("reset");
    rst = 0;

    // 1: four bytes in, one 4-byte word out
    push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h44);
    pop_w(2'd3);
    chk("t1_word", 64'(word_out), 64'h44332211);
    chk("t1_occ", 64'(occupancy), 64'd0);

    // 2: 2-byte word in, two bytes out
    push_w(2'd1, 32'h0000BEEF);
    chk("t2_occ2", 64'(occupancy), 64'd2);
    pop_b();
    chk("t2_ef", 64'(byte_out), 64'hEF);
    chk("t2_occ1", 64'(occupancy), 64'd1);
    pop_b();
    chk("t2_be", 64'(byte_out), 64'hBE);
    chk("t2_occ0", 64'(occupancy), 64'd0);

    // 3: fill, overflow, drain with almost_full edge
    for (int i = 0; i < 16; i++) push_w(2'd3, $urandom);
    chk("t3_full", 64'(occupancy), 64'd64);
    chk("t3_af", 64'(almost_full), 64'd1);
    push_b(8'h5A);
    chk("t3_ovf", 64'(err_overflow), 64'd1);
    chk("t3_occ", 64'(occupancy), 64'd64);
    for (int i = 0; i < 64; i++) begin
      pop_b();
      if (i == 7) chk("t3_af56", 64'(almost_full), 64'd1);
      if (i == 8) chk("t3_af55", 64'(almost_full), 64'd0);
    end

    // 4: wrap-around word reads
    clear = 1; step("clear4");
    for (int i = 0; i < 15; i++) push_w(2'd3, $urandom);
    for (int i = 0; i < 15; i++) pop_w(2'd3);
    for (int i = 1; i <= 8; i++) push_b(8'(i));
    pop_w(2'd3);
    chk("t4_w0", 64'(word_out), 64'h04030201);
    pop_w(2'd3);
    chk("t4_w1", 64'(word_out), 64'h08070605);

    // 5: underflow keeps data and output, clear drops flags
    push_b(8'hA1); push_b(8'hA2);
    pop_w(2'd3);
    chk("t5_udf", 64'(err_underflow), 64'd1);
    chk("t5_occ", 64'(occupancy), 64'd2);
    chk("t5_word", 64'(word_out), 64'h08070605);
    clear = 1; step("clear5");
    chk("t5_clr_udf", 64'(err_underflow), 64'd0);
    chk("t5_clr_occ", 64'(occupancy), 64'd0);

    // 6: collision, concurrent push/pop, async reset
    store_byte = 1; byte_in = 8'hAA;
    store_word = 1; data_size = 2'd3; word_in = 32'hD4C3B2A1;
    step("collide");
    chk("t6_col", 64'(err_collision), 64'd1);
    chk("t6_occ4", 64'(occupancy), 64'd4);
    store_word = 1; data_size = 2'd3; word_in = 32'h44332211; get_byte = 1;
    step("pushpop");
    chk("t6_occ7", 64'(occupancy), 64'd7);
    chk("t6_byte", 64'(byte_out), 64'hA1);
    #2 rst = 1;
    #1;
    model_reset();
    check_all("midrst");
    #1 rst = 0;

    // randomized traffic with alternating fill/drain bias
    for (int c = 0; c < 3000; c++) begin
      bit fill;
      fill = ((c / 60) % 2) == 0;
      store_byte = ($urandom_range(99) < (fill ? 45 : 15));
      store_word = ($urandom_range(99) < (fill ? 40 : 10));
      get_byte   = ($urandom_range(99) < (fill ? 15 : 45));
      get_word   = ($urandom_range(99) < (fill ? 10 : 40));
      data_size  = 2'($urandom_range(3));
      byte_in    = 8'($urandom);
      word_in    = $urandom;
      clear      = ($urandom_range(399) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
